sspim_seq: RTL
==============

SSPIM_SEQ -- requirements
Module: sspim_seq

Interface
REQ-001 SHALL have parameter CTRL_ADDR, default 8'h00, meaning the SPI master control register address (bit 31 = op_req, self-clearing on completion).
REQ-002 SHALL have parameter WDATA_ADDR, default 8'h04, meaning the SPI master transmit data register address.
REQ-003 SHALL have parameter RDATA_ADDR, default 8'h08, meaning the SPI master receive data register address.
REQ-004 SHALL have parameter POLL_TMO, default 16'hFFFF, meaning the maximum poll reads per word before an error is flagged.
REQ-005 Ports (name  direction  width  meaning):
 clk  in  1  single clock; reset_n  in  1  synchronous active-low reset;
 cmd_valid  in  1  block request; cmd_ready  out  1  accept;
 cmd_ctrl  in  32  control-word template (op type, size, cs, period); cmd_cnt  in  8  word count, 0 means 256;
 tx_valid  in  1; tx_ready  out  1; tx_data  in  32  outbound word;
 rx_valid  out  1; rx_ready  in  1; rx_data  out  32  received word;
 m_reg_cs  out  1; m_reg_wr  out  1; m_reg_addr  out  8; m_reg_wdata  out  32; m_reg_be  out  4; m_reg_rdata  in  32; m_reg_ack  in  1  (register-bus master toward SPI master);
 busy  out  1  block in progress; done  out  1  one-cycle end pulse; err  out  1  one-cycle poll-timeout pulse.

Function
REQ-006 SHALL implement FSM states IDLE, WR_DATA, WR_CTRL, POLL, RD_DATA, PUSH, FIN.
REQ-007 SHALL assert cmd_ready only in IDLE; on cmd_valid&cmd_ready, latch cmd_ctrl and cmd_cnt, go to WR_DATA.
REQ-008 WR_DATA: SHALL wait for tx_valid, pulse tx_ready one cycle, issue write of tx_data to WDATA_ADDR, go to WR_CTRL on m_reg_ack.
REQ-009 WR_CTRL: SHALL write {1'b1, ctrl[30:0]} to CTRL_ADDR, go to POLL on m_reg_ack.
REQ-010 POLL: SHALL read CTRL_ADDR repeatedly; on ack with rdata[31]==0 go to RD_DATA; else increment poll counter and reissue.
REQ-011 POLL: when poll counter reaches POLL_TMO SHALL pulse err, abandon the block, go to FIN.
REQ-012 RD_DATA: SHALL read RDATA_ADDR, capture m_reg_rdata into rx_data on ack, go to PUSH.
REQ-013 PUSH: SHALL hold rx_valid high and rx_data stable until rx_ready; on handshake decrement remaining count; if zero go to FIN else WR_DATA.
REQ-014 FIN: SHALL pulse done for one cycle (also after error), return to IDLE next cycle.
REQ-015 Bus handshake: m_reg_cs, wr, addr, wdata SHALL stay constant from assertion until the ack cycle; cs SHALL be low for at least one cycle after each ack; m_reg_be SHALL be 4'hF.
REQ-016 Bus: m_reg_wdata SHALL be 0 during reads; only one transaction outstanding.
REQ-017 Remaining count SHALL be 9 bits; cmd_cnt==0 loads 256.
REQ-018 busy SHALL equal (state != IDLE).
REQ-019 tx_valid held low SHALL stall in WR_DATA indefinitely with no bus activity; rx_ready low SHALL stall in PUSH indefinitely.

Reset
REQ-020 On reset_n low at a clk edge SHALL enter IDLE, clear counters; outputs cmd_ready=1 after reset, all other outputs 0.
REQ-021 Reset mid-transaction SHALL drop m_reg_cs immediately on the same edge with no completion pulses.

Structure
REQ-022 State enum and default register-address constants SHALL live in shared package sspim_pkg.
REQ-023 Register-bus master handshake SHALL be a sub-module sspim_regm (request in, ack/rdata out).

Verification
REQ-024 cmd_cnt=1, tx 32'hA5A5_1234, bus model clears op_req on 3rd poll -> write 04, write 00 with 32'h8xxx_xxxx, 3 reads of 00, read 08, rx_data = model value, done pulse.
REQ-025 cmd_cnt=4, tx words 1..4 -> 4 complete sequences in order, rx words in order, single done.
REQ-026 POLL_TMO=4, op_req never clears -> err pulse after 4 polls, done next, no RDATA read, return to IDLE.
REQ-027 rx_ready low 20 cycles in PUSH -> rx_data stable, no bus activity, resumes on rx_ready.
REQ-028 reset_n low while m_reg_cs high waiting ack -> cs low next edge, busy=0, cmd_ready=1.
REQ-029 cmd_cnt=0 -> exactly 256 words transferred before done.

Source files
------------

// File: rtl/sspim_pkg.sv
// sspim_pkg -- definitions shared by the SPI-master block sequencer.
//   state_e        : sequencer FSM states, also exported on the debug port
//   DEF_*_ADDR     : default register offsets inside the SPI master
//   DEF_POLL_TMO   : default number of status polls allowed per word
//   word_count()   : converts the 8-bit command count into the 9-bit
//                    number of words, where 0 stands for 256
package sspim_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_CTRL = 3'd2,
    POLL    = 3'd3,
    RD_DATA = 3'd4,
    PUSH    = 3'd5,
    FIN     = 3'd6
  } state_e;

  localparam logic [7:0]  DEF_CTRL_ADDR  = 8'h00;
  localparam logic [7:0]  DEF_WDATA_ADDR = 8'h04;
  localparam logic [7:0]  DEF_RDATA_ADDR = 8'h08;
  localparam logic [15:0] DEF_POLL_TMO   = 16'hFFFF;

  function automatic logic [8:0] word_count(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 9'd256 : {1'b0, cnt};
  endfunction

endpackage

// File: rtl/sspim_seq_if.sv
// sspim_seq_if -- simple register bus between the sequencer and the SPI
// master's register file.
//   m_reg_cs    : transaction strobe, held from issue through the ack cycle
//   m_reg_wr    : 1 = write, 0 = read
//   m_reg_addr  : register offset
//   m_reg_wdata : write data (0 during reads)
//   m_reg_be    : byte enables, all ones while a transaction is open
//   m_reg_rdata : read data, valid in the ack cycle
//   m_reg_ack   : one-cycle completion from the target
// modports: master (sequencer side), slave (register-file side).
interface sspim_seq_if;
  logic        m_reg_cs;
  logic        m_reg_wr;
  logic [7:0]  m_reg_addr;
  logic [31:0] m_reg_wdata;
  logic [3:0]  m_reg_be;
  logic [31:0] m_reg_rdata;
  logic        m_reg_ack;

  modport master (
    output m_reg_cs, m_reg_wr, m_reg_addr, m_reg_wdata, m_reg_be,
    input  m_reg_rdata, m_reg_ack
  );

  modport slave (
    input  m_reg_cs, m_reg_wr, m_reg_addr, m_reg_wdata, m_reg_be,
    output m_reg_rdata, m_reg_ack
  );
endinterface

// File: rtl/sspim_regm.sv
// sspim_regm -- register-bus master that turns a level request from the
// sequencer into one bus transaction at a time.
//   clk, reset_n        : clock, synchronous active-low reset
//   req                 : sequencer wants a transaction (level)
//   req_wr/addr/wdata   : transaction description, sampled at issue
//   ack                 : one-cycle pulse after the bus ack was seen
//   rdata               : read data captured in the bus ack cycle
//   bus                 : register bus (master side)
// The request is latched when the strobe rises, so the bus fields cannot
// move while the transaction is open. A new transaction is never started
// in the cycle where ack is high: that is the cycle the sequencer uses to
// move on, and it also guarantees the strobe stays low after every ack.
module sspim_regm
  import sspim_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        req_wr,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        ack,
  output logic [31:0] rdata,
  sspim_seq_if.master bus
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.m_reg_cs    <= 1'b0;
      bus.m_reg_wr    <= 1'b0;
      bus.m_reg_addr  <= 8'h00;
      bus.m_reg_wdata <= 32'h0;
      bus.m_reg_be    <= 4'h0;
      ack             <= 1'b0;
      rdata           <= 32'h0;
    end else begin
      ack <= 1'b0;
      if (bus.m_reg_cs) begin
        if (bus.m_reg_ack) begin
          bus.m_reg_cs    <= 1'b0;
          bus.m_reg_wr    <= 1'b0;
          bus.m_reg_addr  <= 8'h00;
          bus.m_reg_wdata <= 32'h0;
          bus.m_reg_be    <= 4'h0;
          ack             <= 1'b1;
          rdata           <= bus.m_reg_rdata;
        end
      end else if (req && !ack) begin
        bus.m_reg_cs    <= 1'b1;
        bus.m_reg_wr    <= req_wr;
        bus.m_reg_addr  <= req_addr;
        bus.m_reg_wdata <= req_wr ? req_wdata : 32'h0;
        bus.m_reg_be    <= 4'hF;
      end
    end
  end

endmodule

// File: rtl/sspim_seq.sv
// sspim_seq -- block sequencer for an SPI master with a register interface.
// For each word of a block: write the word to the transmit register, start
// the operation by writing the control register with op_req set, poll the
// control register until op_req clears, read the receive register and hand
// the result out on the rx stream.
//   clk, reset_n          : clock, synchronous active-low reset
//   cmd_valid/ready       : block request; cmd_ctrl template, cmd_cnt words
//   tx_valid/ready/data   : outbound word stream
//   rx_valid/ready/data   : received word stream
//   m_reg                 : register bus toward the SPI master
//   busy                  : block in progress
//   done                  : one-cycle pulse when a block ends (also on error)
//   err                   : one-cycle pulse when a word's poll budget ran out
//   dbg_state             : current FSM state
// Streams use valid/ready: a transfer happens on a rising clk edge where
// both are high; the source keeps valid and its data steady until then.
// tx_ready is raised for a single cycle once tx_valid has been seen in
// WR_DATA, and the word is taken in that cycle.
module sspim_seq
  import sspim_pkg::*;
#(
  parameter logic [7:0]  CTRL_ADDR  = DEF_CTRL_ADDR,
  parameter logic [7:0]  WDATA_ADDR = DEF_WDATA_ADDR,
  parameter logic [7:0]  RDATA_ADDR = DEF_RDATA_ADDR,
  parameter logic [15:0] POLL_TMO   = DEF_POLL_TMO
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_ctrl,
  input  logic [7:0]  cmd_cnt,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [31:0] rx_data,
  sspim_seq_if.master m_reg,
  output logic        busy,
  output logic        done,
  output logic        err,
  output state_e      dbg_state
);

  state_e      state;
  logic [30:0] ctrl_q;     // op_req bit is always forced on when written
  logic [8:0]  remain;
  logic [15:0] poll_cnt;
  logic [31:0] wdata_q;
  logic        word_ok;    // outbound word captured, write may be issued

  logic        bus_req;
  logic        bus_wr;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Each bus-facing state requests exactly one kind of transaction.
  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = 8'h00;
    bus_wdata = 32'h0;
    case (state)
      WR_DATA: begin
        bus_req   = word_ok;
        bus_wr    = 1'b1;
        bus_addr  = WDATA_ADDR;
        bus_wdata = wdata_q;
      end
      WR_CTRL: begin
        bus_req   = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = CTRL_ADDR;
        bus_wdata = {1'b1, ctrl_q};
      end
      POLL: begin
        bus_req  = 1'b1;
        bus_addr = CTRL_ADDR;
      end
      RD_DATA: begin
        bus_req  = 1'b1;
        bus_addr = RDATA_ADDR;
      end
      default: ;
    endcase
  end

  sspim_regm u_regm (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (bus_req),
    .req_wr    (bus_wr),
    .req_addr  (bus_addr),
    .req_wdata (bus_wdata),
    .ack       (bus_ack),
    .rdata     (bus_rdata),
    .bus       (m_reg)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      ctrl_q   <= 31'h0;
      remain   <= 9'd0;
      poll_cnt <= 16'd0;
      wdata_q  <= 32'h0;
      word_ok  <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 32'h0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ctrl_q <= cmd_ctrl[30:0];
            remain <= word_count(cmd_cnt);
            state  <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (!word_ok) begin
            if (tx_ready) begin
              tx_ready <= 1'b0;
              if (tx_valid) begin
                wdata_q <= tx_data;
                word_ok <= 1'b1;
              end
            end else if (tx_valid) begin
              tx_ready <= 1'b1;
            end
          end else if (bus_ack) begin
            word_ok <= 1'b0;
            state   <= WR_CTRL;
          end
        end
        WR_CTRL: begin
          if (bus_ack) begin
            poll_cnt <= 16'd0;
            state    <= POLL;
          end
        end
        POLL: begin
          if (bus_ack) begin
            if (!bus_rdata[31]) begin
              state <= RD_DATA;
            end else if (({1'b0, poll_cnt} + 17'd1) >= {1'b0, POLL_TMO}) begin
              // Poll budget used up: the rest of the block is dropped.
              err   <= 1'b1;
              state <= FIN;
            end else begin
              poll_cnt <= poll_cnt + 16'd1;
            end
          end
        end
        RD_DATA: begin
          if (bus_ack) begin
            rx_data  <= bus_rdata;
            rx_valid <= 1'b1;
            state    <= PUSH;
          end
        end
        PUSH: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            remain   <= remain - 9'd1;
            state    <= (remain == 9'd1) ? FIN : WR_DATA;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
